fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Parametrised successor to the W4823 FIR sequencer. Single-clock, ungated controller that sequences sample latch, NTAPS multiplies, interleaved accumulation, partial-sum reduction and final normalising add on a pipelined FP ALU of latency ALU_LAT. Adds a decimation mode and a din_valid/din_ready handshake. Drives DMEM/CMEM/REGF addresses and enables, ALU opcode and operand-mux selects; the datapath stays outside this block.

Parameters:
NTAPS, 64, tap count; power of two, >= ALU_LAT
AW, 6, address width, log2(NTAPS)
ALU_LAT, 5, ALU pipeline latency in cycles; >= 2
DECIM, 1, output decimation factor, 1..255

Ports:
clk_fast  in  1  fast clock
rst_n  in  1  async active-low reset
din_valid  in  1  input sample offered
din_ready  out  1  sample accepted this cycle when din_valid=1
cload  in  1  coefficient write strobe
caddr  in  AW  coefficient address
cload_drop  out  1  one-cycle pulse: cload ignored because busy
dmem_we  out  1  DMEM write enable
dmem_addr  out  AW  DMEM address
cmem_we  out  1  CMEM write enable
cmem_addr  out  AW  CMEM address (caddr when loading)
rf_we  out  1  REGF write enable
rf_addr  out  AW  REGF address
alu_op  out  2  10=MUL, 11=ADD29i, 00=ADD29i+normalise
sel_a  out  2  0=DMEM, 1=din, 2=REGF, 3=partial reg
sel_b  out  2  0=CMEM, 1=zero, 2=ALU Y, 3=partial reg
psum_we  out  1  capture ALU Y into partial register psum_idx
psum_idx  out  3  partial register index
dout_valid  out  1  one-cycle pulse: ALU Y holds the filter output
busy  out  1  not IDLE

Behaviour:
- Reset: state IDLE; wptr=0, decim_cnt=0; all enables, busy, dout_valid and cload_drop 0; alu_op=00; selects 0. Reset mid-sequence aborts immediately. DMEM/CMEM contents are not cleared.
- IDLE: din_ready=1. On din_valid: dmem_we=1 at wptr; wptr+1 mod NTAPS.
  - If decim_cnt != DECIM-1: decim_cnt+1; stay IDLE.
  - Otherwise: decim_cnt=0; go to MUL.
- MUL, k=0..NTAPS-1: alu_op=MUL; dmem_addr=(wptr_at_accept-k) mod NTAPS; cmem_addr=k; rf_we at cycle k+ALU_LAT, rf_addr=k.
- DRAIN: ALU_LAT cycles, completing REGF writes.
- ACC, k=0..NTAPS-1: alu_op=ADD; sel_a=REGF, rf_addr=k; sel_b=zero for k<ALU_LAT, else ALU Y. This gives ALU_LAT interleaved lanes.
- CAPT: ALU_LAT cycles; psum_we with psum_idx=0..ALU_LAT-1 captures the lane results.
- RED: ALU_LAT-1 adds, each followed by ALU_LAT-1 wait cycles.
  - First add: P0+P1.
  - Each later add: ALU Y + P[i].
  - The last add uses alu_op=00.
- dout_valid: pulses ALU_LAT cycles after the last issue; state returns to IDLE in the same cycle.
- Latency: acceptance at cycle 0 gives dout_valid at cycle 2*NTAPS+ALU_LAT^2+ALU_LAT+1 (159 at defaults).
- din_ready=0 whenever busy; no input is lost because din_valid is held by the source.
- cload:
  - In IDLE: cmem_we=1, cmem_addr=caddr.
  - When busy: ignored, cload_drop pulses.
  - If cload and din_valid arrive in the same IDLE cycle, cload wins and din_ready=0.

Optional Feature:
FIR_CBANK_EN: CMEM becomes two banks and cmem_addr widens to AW+1, with MSB = bank.
- Adds input cswap. cload always writes the inactive bank, including when busy; cload_drop is tied 0.
- cswap sets a pending flag. The active bank toggles at the next compute-triggering acceptance, never mid-sequence.
- Without the macro: single bank, behaviour as above.

Decomposition:
- Package fir_pkg: opcode constants (OP_MUL, OP_ADD, OP_ADDN), sel_a/sel_b encodings, state enum (IDLE, MUL, DRAIN, ACC, CAPT, RED).
- Sub-module fir_phase_cnt: loadable down-counter with terminal-count flag, reused for every phase length.

Test Plan:
- Reset, then one sample with NTAPS=64, ALU_LAT=5 -> din_ready drops next cycle; dout_valid exactly at cycle 159; dmem_addr in MUL runs 0,63,62,...,1.
- Impulse 1.0 into coefficients c[k]=k -> outputs 0,1,2,...,63 on successive samples, then 0.
- DECIM=4, 8 back-to-back samples -> exactly 2 dout_valid pulses; samples 1-3 and 5-7 take 1 cycle each.
- cload while busy -> cload_drop pulse, CMEM unchanged. cload and din_valid together in IDLE -> coefficient written, sample accepted the next cycle.
- rst_n asserted at ACC k=10 -> all outputs at reset values; the next sample gives the correct result with wptr restarted at 0.
- FIR_CBANK_EN: load bank1 mid-run, then cswap -> the current output uses bank0 and the next output uses bank1 coefficients.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg : opcode, operand-select and state encodings for fir_seq_ctrl
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fir_pkg;

  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;
  localparam logic [1:0] OP_ADDN = 2'b00;

  localparam logic [1:0] SELA_DMEM = 2'd0;
  localparam logic [1:0] SELA_DIN  = 2'd1;
  localparam logic [1:0] SELA_REGF = 2'd2;
  localparam logic [1:0] SELA_PSUM = 2'd3;

  localparam logic [1:0] SELB_CMEM = 2'd0;
  localparam logic [1:0] SELB_ZERO = 2'd1;
  localparam logic [1:0] SELB_ALUY = 2'd2;
  localparam logic [1:0] SELB_PSUM = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DRAIN = 3'd2,
    ACC   = 3'd3,
    CAPT  = 3'd4,
    RED   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fir_phase_cnt.sv
// ---------------------------------------------------------------------------
// fir_phase_cnt : loadable down-counter, o_tc high while the count is zero
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fir_phase_cnt #(
  parameter int CW = 8
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_seq_ctrl : FIR sequencer (latch, MUL, DRAIN, ACC, CAPT, RED) with
// decimation and din handshake. Optional macro FIR_CBANK_EN: dual CMEM bank.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS   = 64,
  parameter int AW      = 6,
  parameter int ALU_LAT = 5,
  parameter int DECIM   = 1
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          i_din_valid,
  output logic          o_din_ready,
  input  logic          i_cload,
  input  logic [AW-1:0] i_caddr,
`ifdef FIR_CBANK_EN
  input  logic          i_cswap,
  output logic [AW:0]   o_cmem_addr,
`else
  output logic [AW-1:0] o_cmem_addr,
`endif
  output logic          o_cload_drop,
  output logic          o_dmem_we,
  output logic [AW-1:0] o_dmem_addr,
  output logic          o_cmem_we,
  output logic          o_rf_we,
  output logic [AW-1:0] o_rf_addr,
  output logic [1:0]    o_alu_op,
  output logic [1:0]    o_sel_a,
  output logic [1:0]    o_sel_b,
  output logic          o_psum_we,
  output logic [2:0]    o_psum_idx,
  output logic          o_dout_valid,
  output logic          o_busy
);

  localparam int CW = $clog2(NTAPS + ALU_LAT * ALU_LAT + 1);
  localparam logic [CW-1:0] c_LEN_TAPS = CW'(NTAPS - 1);
  localparam logic [CW-1:0] c_LEN_LAT  = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] c_LAST_RED = CW'(ALU_LAT - 2);
  localparam logic [CW-1:0] c_LAT      = CW'(ALU_LAT);
  localparam logic [CW-1:0] c_NTAPS    = CW'(NTAPS);
  localparam logic [7:0]    c_DECIM_LAST = 8'(DECIM - 1);

  state_t        r_state, w_next;
  logic [AW-1:0] r_wptr, r_base;
  logic [7:0]    r_decim;
  logic [CW-1:0] r_k, r_ri, w_load_val, w_t;
  logic          r_dout_valid;
  logic          w_load, w_tc, w_ri_inc, w_accept, w_trigger;
  logic [AW-1:0] w_cmem_lo;

  fir_phase_cnt #(.CW(CW)) u_phase (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_val    (w_load_val),
    .o_tc     (w_tc)
  );

  // cload has priority over a sample offered in the same idle cycle
  assign w_accept  = (r_state == IDLE) && i_din_valid && !i_cload;
  assign w_trigger = w_accept && (r_decim == c_DECIM_LAST);
  // time since MUL start; REGF write of tap j lands at j+ALU_LAT
  assign w_t       = (r_state == DRAIN) ? (r_k + c_NTAPS) : r_k;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wptr       <= '0;
      r_base       <= '0;
      r_decim      <= '0;
      r_k          <= '0;
      r_ri         <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_k          <= w_load ? '0 : r_k + 1'b1;
      r_dout_valid <= (r_state == RED) && w_tc && (r_ri == c_LAST_RED);
      if (r_state == CAPT) r_ri <= '0;
      else if (w_ri_inc)   r_ri <= r_ri + 1'b1;
      if (w_accept) begin
        r_wptr  <= r_wptr + 1'b1;
        r_decim <= w_trigger ? 8'd0 : r_decim + 8'd1;
      end
      if (w_trigger) r_base <= r_wptr;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_val   = c_LEN_LAT;
    w_ri_inc     = 1'b0;
    o_din_ready  = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_cmem_we    = 1'b0;
    w_cmem_lo    = '0;
    o_rf_we      = 1'b0;
    o_rf_addr    = '0;
    o_alu_op     = OP_ADDN;
    o_sel_a      = SELA_DMEM;
    o_sel_b      = SELB_CMEM;
    o_psum_we    = 1'b0;
    o_psum_idx   = '0;
    o_cload_drop = 1'b0;
    case (r_state)
      IDLE: begin
        o_din_ready = !i_cload;
        o_dmem_we   = w_accept;
        o_dmem_addr = r_wptr;
        o_cmem_we   = i_cload;
        w_cmem_lo   = i_caddr;
        if (w_trigger) begin
          w_next     = MUL;
          w_load     = 1'b1;
          w_load_val = c_LEN_TAPS;
        end
      end
      MUL, DRAIN: begin
        if (r_state == MUL) begin
          o_alu_op    = OP_MUL;
          o_dmem_addr = r_base - r_k[AW-1:0];
          w_cmem_lo   = r_k[AW-1:0];
        end
        o_rf_we   = (w_t >= c_LAT);
        o_rf_addr = AW'(w_t - c_LAT);
        if (w_tc) begin
          w_next = (r_state == MUL) ? DRAIN : ACC;
          w_load = 1'b1;
          if (r_state == DRAIN) w_load_val = c_LEN_TAPS;
        end
      end
      ACC: begin
        o_alu_op  = OP_ADD;
        o_sel_a   = SELA_REGF;
        o_rf_addr = r_k[AW-1:0];
        // first ALU_LAT issues seed the lanes, later ones chain onto ALU Y
        o_sel_b   = (r_k < c_LAT) ? SELB_ZERO : SELB_ALUY;
        if (w_tc) begin
          w_next = CAPT;
          w_load = 1'b1;
        end
      end
      CAPT: begin
        o_psum_we  = 1'b1;
        o_psum_idx = r_k[2:0];
        if (w_tc) begin
          w_next = RED;
          w_load = 1'b1;
        end
      end
      RED: begin
        if (r_k == '0) begin
          o_alu_op = (r_ri == c_LAST_RED) ? OP_ADDN : OP_ADD;
          o_sel_a  = SELA_PSUM;
          if (r_ri == '0) begin
            o_sel_b    = SELB_PSUM;
            o_psum_idx = 3'd0;
          end else begin
            o_sel_b    = SELB_ALUY;
            o_psum_idx = r_ri[2:0] + 3'd1;
          end
        end
        if (w_tc) begin
          if (r_ri == c_LAST_RED) begin
            w_next = IDLE;
          end else begin
            w_load   = 1'b1;
            w_ri_inc = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE) o_cload_drop = i_cload;
`ifdef FIR_CBANK_EN
    o_cload_drop = 1'b0;
    o_cmem_we    = i_cload;
    if (i_cload) w_cmem_lo = i_caddr;
`endif
  end

`ifdef FIR_CBANK_EN
  logic r_bank, r_pend;

  // bank flips only at a compute-triggering acceptance
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_trigger && r_pend) r_bank <= ~r_bank;
      r_pend <= (r_pend && !w_trigger) || i_cswap;
    end
  end

  assign o_cmem_addr = {(i_cload ? ~r_bank : r_bank), w_cmem_lo};
`else
  assign o_cmem_addr = w_cmem_lo;
`endif

  assign o_busy       = (r_state != IDLE);
  assign o_dout_valid = r_dout_valid;

endmodule

`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_seq_ctrl : directed self-checking bench for fir_seq_ctrl
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_seq_ctrl;

  logic clk_fast = 1'b0;
  logic rst_n;
  always #5 clk_fast = ~clk_fast;

  int errors = 0;
  int checks = 0;

  // instance A: defaults (NTAPS=64, ALU_LAT=5, DECIM=1)
  logic       a_din_valid, a_din_ready, a_cload, a_cload_drop;
  logic [5:0] a_caddr, a_dmem_addr, a_rf_addr;
`ifdef FIR_CBANK_EN
  logic [6:0] a_cmem_addr;
`else
  logic [5:0] a_cmem_addr;
`endif
  logic       a_dmem_we, a_cmem_we, a_rf_we, a_psum_we, a_dout_valid, a_busy;
  logic [1:0] a_alu_op, a_sel_a, a_sel_b;
  logic [2:0] a_psum_idx;

  // instance B: NTAPS=8, ALU_LAT=4, DECIM=4
  logic       b_din_valid, b_din_ready, b_cload, b_cload_drop;
  logic [2:0] b_caddr, b_dmem_addr, b_rf_addr;
`ifdef FIR_CBANK_EN
  logic [3:0] b_cmem_addr;
`else
  logic [2:0] b_cmem_addr;
`endif
  logic       b_dmem_we, b_cmem_we, b_rf_we, b_psum_we, b_dout_valid, b_busy;
  logic [1:0] b_alu_op, b_sel_a, b_sel_b;
  logic [2:0] b_psum_idx;

  fir_seq_ctrl u_a (
    .clk_fast(clk_fast), .rst_n(rst_n),
    .i_din_valid(a_din_valid), .o_din_ready(a_din_ready),
    .i_cload(a_cload), .i_caddr(a_caddr),
`ifdef FIR_CBANK_EN
    .i_cswap(1'b0),
`endif
    .o_cmem_addr(a_cmem_addr), .o_cload_drop(a_cload_drop),
    .o_dmem_we(a_dmem_we), .o_dmem_addr(a_dmem_addr), .o_cmem_we(a_cmem_we),
    .o_rf_we(a_rf_we), .o_rf_addr(a_rf_addr), .o_alu_op(a_alu_op),
    .o_sel_a(a_sel_a), .o_sel_b(a_sel_b), .o_psum_we(a_psum_we),
    .o_psum_idx(a_psum_idx), .o_dout_valid(a_dout_valid), .o_busy(a_busy)
  );

  fir_seq_ctrl #(.NTAPS(8), .AW(3), .ALU_LAT(4), .DECIM(4)) u_b (
    .clk_fast(clk_fast), .rst_n(rst_n),
    .i_din_valid(b_din_valid), .o_din_ready(b_din_ready),
    .i_cload(b_cload), .i_caddr(b_caddr),
`ifdef FIR_CBANK_EN
    .i_cswap(1'b0),
`endif
    .o_cmem_addr(b_cmem_addr), .o_cload_drop(b_cload_drop),
    .o_dmem_we(b_dmem_we), .o_dmem_addr(b_dmem_addr), .o_cmem_we(b_cmem_we),
    .o_rf_we(b_rf_we), .o_rf_addr(b_rf_addr), .o_alu_op(b_alu_op),
    .o_sel_a(b_sel_a), .o_sel_b(b_sel_b), .o_psum_we(b_psum_we),
    .o_psum_idx(b_psum_idx), .o_dout_valid(b_dout_valid), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one full sequence on instance A, accepted at cycle 0 with wptr 0.
  task automatic run_full(input string nm);
    int got;
    got = -1;
    for (int c = 1; c <= 220 && got < 0; c++) begin
      @(negedge clk_fast);
      a_din_valid = 1'b0;
      #1;
      if (c == 1) begin
        chk({nm, "_busy_c1"}, a_busy, 1);
        chk({nm, "_ready_c1"}, a_din_ready, 0);
        chk({nm, "_op_mul"}, a_alu_op, 2);
      end
      if (c <= 64) begin
        chk({nm, "_dmem_mul"}, a_dmem_addr, (65 - c) % 64);
        chk({nm, "_cmem_mul"}, a_cmem_addr, c - 1);
      end
      if (c == 5)  chk({nm, "_rfwe_c5"}, a_rf_we, 0);
      if (c == 6) begin
        chk({nm, "_rfwe_c6"}, a_rf_we, 1);
        chk({nm, "_rfaddr_c6"}, a_rf_addr, 0);
      end
      if (c == 69) begin
        chk({nm, "_rfwe_c69"}, a_rf_we, 1);
        chk({nm, "_rfaddr_c69"}, a_rf_addr, 63);
      end
      if (c == 70) begin
        chk({nm, "_rfwe_c70"}, a_rf_we, 0);
        chk({nm, "_op_acc"}, a_alu_op, 3);
        chk({nm, "_sela_acc"}, a_sel_a, 2);
        chk({nm, "_selb_acc0"}, a_sel_b, 1);
      end
      if (c == 74) chk({nm, "_selb_acc4"}, a_sel_b, 1);
      if (c == 75) begin
        chk({nm, "_selb_acc5"}, a_sel_b, 2);
        chk({nm, "_rfaddr_acc5"}, a_rf_addr, 5);
      end
      if (c == 134) begin
        chk({nm, "_psumwe_c134"}, a_psum_we, 1);
        chk({nm, "_psumidx_c134"}, a_psum_idx, 0);
      end
      if (c == 138) chk({nm, "_psumidx_c138"}, a_psum_idx, 4);
      if (c == 139) begin
        chk({nm, "_op_red0"}, a_alu_op, 3);
        chk({nm, "_sela_red0"}, a_sel_a, 3);
        chk({nm, "_selb_red0"}, a_sel_b, 3);
      end
      if (c == 144) begin
        chk({nm, "_selb_red1"}, a_sel_b, 2);
        chk({nm, "_psumidx_red1"}, a_psum_idx, 2);
      end
      if (c == 154) begin
        chk({nm, "_op_redlast"}, a_alu_op, 0);
        chk({nm, "_sela_redlast"}, a_sel_a, 3);
        chk({nm, "_psumidx_redlast"}, a_psum_idx, 4);
      end
      if (c == 158) chk({nm, "_busy_c158"}, a_busy, 1);
      if (a_dout_valid) got = c;
    end
    chk({nm, "_latency"}, got, 159);
    chk({nm, "_busy_at_dout"}, a_busy, 0);
    chk({nm, "_ready_at_dout"}, a_din_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[8];
    int nacc, npulse;
    rst_n       = 1'b0;
    a_din_valid = 1'b0; a_cload = 1'b0; a_caddr = '0;
    b_din_valid = 1'b0; b_cload = 1'b0; b_caddr = '0;
    repeat (3) @(negedge clk_fast);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_din_ready, 1);
    chk("rst_dout", a_dout_valid, 0);
    chk("rst_op", a_alu_op, 0);
    chk("rst_sela", a_sel_a, 0);
    chk("rst_selb", a_sel_b, 0);
    chk("rst_dmemwe", a_dmem_we, 0);
    chk("rst_rfwe", a_rf_we, 0);
    chk("rst_psumwe", a_psum_we, 0);
    chk("rst_drop", a_cload_drop, 0);

    // single sample, full sequence
    @(negedge clk_fast);
    a_din_valid = 1'b1;
    #1;
    chk("t1_ready", a_din_ready, 1);
    chk("t1_dmemwe", a_dmem_we, 1);
    chk("t1_dmemaddr", a_dmem_addr, 0);
    run_full("t1");

    // cload and din_valid together in IDLE: cload wins
    @(negedge clk_fast);
    a_cload = 1'b1; a_caddr = 6'd7; a_din_valid = 1'b1;
    #1;
    chk("cl_cmemwe", a_cmem_we, 1);
    chk("cl_cmemaddr", a_cmem_addr, 7);
    chk("cl_ready", a_din_ready, 0);
    chk("cl_dmemwe", a_dmem_we, 0);
    @(negedge clk_fast);
    a_cload = 1'b0;
    #1;
    chk("cl_next_ready", a_din_ready, 1);
    chk("cl_next_dmemwe", a_dmem_we, 1);
    chk("cl_next_dmemaddr", a_dmem_addr, 1);
    @(negedge clk_fast);
    a_din_valid = 1'b0;
    #1;
    chk("t2_busy", a_busy, 1);
    chk("t2_dmem_k0", a_dmem_addr, 1);
    // cload while busy is dropped
    @(negedge clk_fast);
    a_cload = 1'b1; a_caddr = 6'd3;
    #1;
    chk("drop_pulse", a_cload_drop, 1);
    chk("drop_cmemwe", a_cmem_we, 0);
    @(negedge clk_fast);
    a_cload = 1'b0;
    #1;
    chk("drop_end", a_cload_drop, 0);
    chk("t2_dmem_k2", a_dmem_addr, 63);
    repeat (77) @(negedge clk_fast);
    #1;
    chk("acc10_rfaddr", a_rf_addr, 10);
    chk("acc10_sela", a_sel_a, 2);
    // abort mid-ACC
    rst_n = 1'b0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_op", a_alu_op, 0);
    chk("abort_sela", a_sel_a, 0);
    chk("abort_selb", a_sel_b, 0);
    chk("abort_rfwe", a_rf_we, 0);
    chk("abort_dout", a_dout_valid, 0);
    chk("abort_ready", a_din_ready, 1);
    @(negedge clk_fast);
    rst_n = 1'b1;
    @(negedge clk_fast);
    a_din_valid = 1'b1;
    #1;
    chk("t3_dmemwe", a_dmem_we, 1);
    chk("t3_wptr0", a_dmem_addr, 0);
    run_full("t3");

    // decimation by 4 on instance B: 8 back-to-back samples
    nacc = 0;
    npulse = 0;
    for (int i = 0; i < 8; i++) acc_cyc[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_fast);
      b_din_valid = (nacc < 8);
      #1;
      if (b_din_valid && b_din_ready) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      if (b_dout_valid) npulse++;
    end
    chk("dec_accepts", nacc, 8);
    chk("dec_pulses", npulse, 2);
    chk("dec_gap01", acc_cyc[1] - acc_cyc[0], 1);
    chk("dec_gap12", acc_cyc[2] - acc_cyc[1], 1);
    chk("dec_gap23", acc_cyc[3] - acc_cyc[2], 1);
    chk("dec_gap34", acc_cyc[4] - acc_cyc[3], 37);
    chk("dec_gap45", acc_cyc[5] - acc_cyc[4], 1);
    chk("dec_gap56", acc_cyc[6] - acc_cyc[5], 1);
    chk("dec_gap67", acc_cyc[7] - acc_cyc[6], 1);
    chk("dec_idle_end", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
